// File: rtl/clk_ratio_meter_if.sv
// Bundle of the signals between the divider-side driver and the ratio meter.
// The master drives the measurement controls and the divided clock. The slave
// (the meter) returns the measurement results and status flags.
interface clk_ratio_meter_if #(
  parameter int WIDTH = 8
);
  logic             meas_en;
  logic [WIDTH-1:0] exp_ratio;
  logic             div_clk;
  logic [WIDTH:0]   period;
  logic [WIDTH:0]   high_time;
  logic             valid;
  logic             match;
  logic             err;
  logic             timeout;
  logic             bypass;

  modport master (
    output meas_en, exp_ratio, div_clk,
    input  period, high_time, valid, match, err, timeout, bypass
  );

  modport slave (
    input  meas_en, exp_ratio, div_clk,
    output period, high_time, valid, match, err, timeout, bypass
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// Receive-side checker for the programmable clock divider.
// The divided clock is sampled as data in the reference clock domain. The meter
// measures its period and high time in reference cycles and compares both with
// the expected ratio. It flags mismatches and a lost clock (no rising edge
// before the period counter saturates). Ratios 0 and 1 mean the divider passes
// the reference clock through, so no check is made and bypass is reported.
module clk_ratio_meter #(
  parameter int WIDTH = 8
) (
  input logic              ref_clk,
  input logic              rst_n,
  clk_ratio_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [WIDTH:0] CNT_MAX = '1;

  state_t           state;
  logic             div_q;
  logic [WIDTH:0]   cnt;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] ratio_q;

  logic             rise;
  logic             ratio_ok;
  logic             ratio_changed;
  logic [WIDTH:0]   ratio_ext;
  logic [WIDTH:0]   half_lo;
  logic [WIDTH:0]   half_hi;
  logic             meas_ok;
  logic [WIDTH:0]   cnt_inc;
  logic             cnt_sat;

  // Edge detector helpers, ratio decode, and the match rule for the running period.
  always_comb begin
    rise          = bus.div_clk & ~div_q;
    ratio_ok      = bus.exp_ratio > WIDTH'(1);
    ratio_changed = bus.exp_ratio != ratio_q;
    ratio_ext     = {1'b0, bus.exp_ratio};
    // Odd ratios may put the extra cycle in either half of the period.
    half_lo       = ratio_ext >> 1;
    half_hi       = (ratio_ext + 1'b1) >> 1;
    meas_ok       = (cnt == ratio_ext) && ((hi == half_lo) || (hi == half_hi));
    cnt_inc       = cnt + 1'b1;
    cnt_sat       = cnt_inc == CNT_MAX;
  end

  // One-cycle delayed copy of the divided clock, used for rising-edge detection.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= bus.div_clk;
    end
  end

  // Measurement FSM with registered results and status flags.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hi            <= '0;
      ratio_q       <= '0;
      bus.period    <= '0;
      bus.high_time <= '0;
      bus.valid     <= 1'b0;
      bus.match     <= 1'b0;
      bus.err       <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.bypass    <= 1'b0;
    end else begin
      bus.valid  <= 1'b0;
      bus.bypass <= ~ratio_ok;

      if (!bus.meas_en || !ratio_ok) begin
        // Disabling, or a pass-through ratio, wins over any edge seen this cycle.
        // Results and sticky flags are kept for software to read.
        state <= IDLE;
        cnt   <= '0;
        hi    <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A fresh enable starts a new error-tracking window.
            state       <= ARM;
            cnt         <= '0;
            hi          <= '0;
            ratio_q     <= bus.exp_ratio;
            bus.err     <= 1'b0;
            bus.timeout <= 1'b0;
          end

          ARM: begin
            // Wait for the first rising edge. The partial period before it is unknown.
            ratio_q <= bus.exp_ratio;
            if (rise) begin
              state <= MEAS;
              cnt   <= {{WIDTH{1'b0}}, 1'b1};
              hi    <= {{WIDTH{1'b0}}, 1'b1};
            end else if (cnt_sat) begin
              bus.timeout <= 1'b1;
              bus.err     <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end

          MEAS: begin
            if (ratio_changed) begin
              // The running period straddles two ratios; drop it and re-arm.
              state   <= ARM;
              ratio_q <= bus.exp_ratio;
              cnt     <= '0;
              hi      <= '0;
            end else if (rise) begin
              bus.period    <= cnt;
              bus.high_time <= hi;
              bus.valid     <= 1'b1;
              bus.match     <= meas_ok;
              if (!meas_ok) begin
                bus.err <= 1'b1;
              end
              cnt <= {{WIDTH{1'b0}}, 1'b1};
              hi  <= {{WIDTH{1'b0}}, 1'b1};
            end else if (cnt_sat) begin
              // Clock stopped mid-period: report the loss and wait for it to return.
              state       <= ARM;
              bus.timeout <= 1'b1;
              bus.err     <= 1'b1;
              cnt         <= '0;
              hi          <= '0;
            end else begin
              cnt <= cnt_inc;
              hi  <= hi + (WIDTH + 1)'(bus.div_clk);
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: drives divided-clock patterns of known
// shape and checks the reported period, high time, match and status flags.
module tb_clk_ratio_meter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_passed;

  clk_ratio_meter_if #(.WIDTH(8)) bus ();

  clk_ratio_meter #(.WIDTH(8)) dut (
    .ref_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive n periods of h high / l low cycles and collect what the meter reports.
  task automatic run_div(input int h, input int l, input int n,
                         output int nvalid, output int nmatch,
                         output int last_p, output int last_h,
                         output int first_step, output int bad_gap);
    int step;
    int last_step;
    nvalid     = 0;
    nmatch     = 0;
    last_p     = -1;
    last_h     = -1;
    first_step = -1;
    bad_gap    = 0;
    step       = 0;
    last_step  = -1;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < h + l; c++) begin
        bus.div_clk = (c < h);
        tick();
        step++;
        if (bus.valid === 1'b1) begin
          nvalid++;
          if (bus.match === 1'b1) nmatch++;
          last_p = int'(bus.period);
          last_h = int'(bus.high_time);
          if (first_step < 0) first_step = step;
          if (last_step >= 0 && (step - last_step) != h + l) bad_gap++;
          last_step = step;
        end
      end
    end
    $display("run h=%0d l=%0d n=%0d: valids=%0d matches=%0d period=%0d high=%0d first=%0d",
             h, l, n, nvalid, nmatch, last_p, last_h, first_step);
  endtask

  initial begin
    int nv, nm, lp, lh, fs, bg, vcount;
    n_checks      = 0;
    n_passed      = 0;
    rst_n         = 1'b0;
    bus.meas_en   = 1'b0;
    bus.exp_ratio = 8'd4;
    bus.div_clk   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_period", bus.period, 0);
    check("rst_high", bus.high_time, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_match", bus.match, 0);
    check("rst_err", bus.err, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_bypass", bus.bypass, 0);
    rst_n = 1'b1;
    tick();

    // 1: ratio 4, 2 high / 2 low, 20 periods
    bus.meas_en = 1'b1;
    tick();
    run_div(2, 2, 20, nv, nm, lp, lh, fs, bg);
    check("t1_nvalid", nv, 19);
    check("t1_nmatch", nm, 19);
    check("t1_period", lp, 4);
    check("t1_high", lh, 2);
    check("t1_first", fs, 5);
    check("t1_gap", bg, 0);
    check("t1_err", bus.err, 0);

    // 2: ratio 5, 3/2 then 2/3; ratio change re-arms first
    bus.exp_ratio = 8'd5;
    tick();
    run_div(3, 2, 6, nv, nm, lp, lh, fs, bg);
    check("t2a_nvalid", nv, 5);
    check("t2a_nmatch", nm, 5);
    check("t2a_period", lp, 5);
    check("t2a_high", lh, 3);
    run_div(2, 3, 6, nv, nm, lp, lh, fs, bg);
    check("t2b_nvalid", nv, 6);
    check("t2b_nmatch", nm, 6);
    check("t2b_period", lp, 5);
    check("t2b_high", lh, 2);
    check("t2_err", bus.err, 0);

    // 3: expect 6, actual /8 (4/4)
    bus.exp_ratio = 8'd6;
    tick();
    run_div(4, 4, 5, nv, nm, lp, lh, fs, bg);
    check("t3_nvalid", nv, 4);
    check("t3_nmatch", nm, 0);
    check("t3_period", lp, 8);
    check("t3_high", lh, 4);
    check("t3_match", bus.match, 0);
    check("t3_err", bus.err, 1);
    bus.meas_en = 1'b0;
    tick();
    tick();
    check("t3_err_held", bus.err, 1);
    check("t3_period_held", bus.period, 8);
    run_div(4, 4, 2, nv, nm, lp, lh, fs, bg);
    check("t3_idle_nvalid", nv, 0);

    // 4: stuck clock, ratio 3 -> timeout after 511 cycles in ARM
    bus.exp_ratio = 8'd3;
    bus.div_clk   = 1'b0;
    bus.meas_en   = 1'b1;
    tick();
    check("t4_err_cleared", bus.err, 0);
    vcount = 0;
    for (int i = 0; i < 510; i++) begin
      tick();
      if (bus.valid === 1'b1) vcount++;
    end
    check("t4_timeout_early", bus.timeout, 0);
    tick();
    if (bus.valid === 1'b1) vcount++;
    check("t4_timeout", bus.timeout, 1);
    check("t4_err", bus.err, 1);
    check("t4_nvalid", vcount, 0);

    // 5: bypass ratios 0 and 1, then ratio 2
    bus.exp_ratio = 8'd0;
    tick();
    check("t5_bypass0", bus.bypass, 1);
    run_div(1, 1, 4, nv, nm, lp, lh, fs, bg);
    check("t5_nvalid0", nv, 0);
    bus.exp_ratio = 8'd1;
    tick();
    check("t5_bypass1", bus.bypass, 1);
    run_div(1, 1, 4, nv, nm, lp, lh, fs, bg);
    check("t5_nvalid1", nv, 0);
    bus.exp_ratio = 8'd2;
    tick();
    check("t5_bypass2", bus.bypass, 0);
    check("t5_err_cleared", bus.err, 0);
    check("t5_timeout_cleared", bus.timeout, 0);
    run_div(1, 1, 6, nv, nm, lp, lh, fs, bg);
    check("t5_nvalid2", nv, 5);
    check("t5_nmatch2", nm, 5);
    check("t5_period2", lp, 2);
    check("t5_high2", lh, 1);
    check("t5_first2", fs, 3);

    // 6: async reset mid-period with ratio 7 (4 high / 3 low)
    bus.exp_ratio = 8'd7;
    tick();
    run_div(4, 3, 3, nv, nm, lp, lh, fs, bg);
    check("t6a_nvalid", nv, 2);
    check("t6a_period", lp, 7);
    bus.div_clk = 1'b1;
    tick();
    tick();
    check("t6_period_pre", bus.period, 7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_period", bus.period, 0);
    check("t6_rst_high", bus.high_time, 0);
    check("t6_rst_match", bus.match, 0);
    check("t6_rst_err", bus.err, 0);
    bus.div_clk = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_div(4, 3, 3, nv, nm, lp, lh, fs, bg);
    check("t6b_nvalid", nv, 2);
    check("t6b_nmatch", nm, 2);
    check("t6b_first", fs, 8);
    check("t6b_period", lp, 7);
    check("t6b_high", lh, 4);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
